// File: rtl/stream_wrr_pkg.sv
// Shared types for the weighted round-robin stream arbiter.
package stream_wrr_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } wrr_state_e;

endpackage

// File: rtl/stream_wrr_pick.sv
// Combinational wrap-around priority search: first set request at or above ptr_i.
module stream_wrr_pick #(
  parameter int N_INP = 4,
  localparam int IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic [N_INP-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // With nothing requested the index parks on ptr_i so idx_o stays stable.
  always_comb begin
    int j;
    idx_o = ptr_i;
    any_o = 1'b0;
    for (int i = 0; i < N_INP; i++) begin
      j = (int'(ptr_i) + i) % N_INP;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin arbiter sharing one valid/ready stream between N_INP inputs.
// Define STREAM_WRR_ARBITER_PKT_EN for packet mode (turns end only on a last beat).
//
// state | meaning
// ARB   | no turn running; pick first eligible input from ptr
// BURST | input cur holds the grant; cnt beats remain in its turn
module stream_wrr_arbiter
  import stream_wrr_pkg::*;
#(
  parameter type DATA_T   = logic,
  parameter int  N_INP    = 4,
  parameter int  WEIGHT_W = 4,
  localparam int IDX_W    = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WEIGHT_W-1:0] weight_i [N_INP],
  input  DATA_T               inp_data_i [N_INP],
  input  logic [N_INP-1:0]    inp_valid_i,
  output logic [N_INP-1:0]    inp_ready_o,
`ifdef STREAM_WRR_ARBITER_PKT_EN
  input  logic [N_INP-1:0]    inp_last_i,
  output logic                oup_last_o,
`endif
  output DATA_T               oup_data_o,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output logic [IDX_W-1:0]    idx_o
);

  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  wrr_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, cur_q, cur_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [N_INP-1:0]    elig;
  logic [IDX_W-1:0]    pick_idx, sel, sel_nxt;
  logic [WEIGHT_W-1:0] sel_w;
  logic                pick_any, sel_valid, sel_last, hs;

  always_comb begin
    for (int i = 0; i < N_INP; i++) begin
      elig[i] = inp_valid_i[i] && (weight_i[i] != '0);
    end
  end

  stream_wrr_pick #(.N_INP(N_INP)) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel       = (state_q == ARB) ? pick_idx : cur_q;
    sel_valid = (state_q == ARB) ? pick_any : inp_valid_i[cur_q];
    sel_w     = weight_i[sel];
    sel_nxt   = (sel == IDX_W'(N_INP - 1)) ? '0 : sel + 1'b1;
    hs        = sel_valid && oup_ready_i;
`ifdef STREAM_WRR_ARBITER_PKT_EN
    sel_last  = inp_last_i[sel];
`else
    sel_last  = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        if (hs && sel_w == ONE && sel_last) begin
          ptr_d = sel_nxt;
        end else if (sel_valid) begin
          // Weight is captured here; later weight_i changes do not touch this turn.
          state_d = BURST;
          cur_d   = sel;
          if (!hs)              cnt_d = sel_w;
          else if (sel_w > ONE) cnt_d = sel_w - ONE;
          else                  cnt_d = ONE;
        end
      end
      BURST: begin
        if (hs) begin
          if (cnt_q == ONE && sel_last) begin
            state_d = ARB;
            ptr_d   = sel_nxt;
          end else if (cnt_q != ONE) begin
            cnt_d = cnt_q - ONE;
          end
        end
`ifndef STREAM_WRR_ARBITER_PKT_EN
        else if (!inp_valid_i[cur_q]) begin
          state_d = ARB;
          ptr_d   = sel_nxt;
        end
`endif
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held.
  always_comb begin
    oup_valid_o = sel_valid && !rst_i;
    idx_o       = rst_i ? '0 : sel;
    oup_data_o  = inp_data_i[idx_o];
    for (int i = 0; i < N_INP; i++) begin
      inp_ready_o[i] = oup_ready_i && oup_valid_o && (idx_o == IDX_W'(i));
    end
`ifdef STREAM_WRR_ARBITER_PKT_EN
    oup_last_o  = inp_last_i[idx_o];
`endif
  end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Scoreboard bench for stream_wrr_arbiter: expected grant indices are queued, a monitor checks each handshake.
module tb_stream_wrr_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      weight [N];
  logic [7:0]      inp_data [N];
  logic [N-1:0]    inp_valid = '0;
  logic [N-1:0]    inp_ready;
  logic [7:0]      oup_data;
  logic            oup_valid;
  logic            oup_ready = 1'b0;
  logic [1:0]      idx;
`ifdef STREAM_WRR_ARBITER_PKT_EN
  logic [N-1:0]    inp_last = '0;
  logic            oup_last;
`endif

  int exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  stream_wrr_arbiter #(.DATA_T(logic [7:0]), .N_INP(N), .WEIGHT_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .weight_i    (weight),
    .inp_data_i  (inp_data),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
`ifdef STREAM_WRR_ARBITER_PKT_EN
    .inp_last_i  (inp_last),
    .oup_last_o  (oup_last),
`endif
    .oup_data_o  (oup_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .idx_o       (idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight[0] = 4'(w0); weight[1] = 4'(w1); weight[2] = 4'(w2); weight[3] = 4'(w3);
  endtask

  task automatic push(input int e);
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    int e;
    if (oup_valid && oup_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat_idx", int'(idx), -1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", int'(idx), e);
        chk("sb_data", int'(oup_data), 'hA0 + e);
        chk("sb_ready", int'(inp_ready), 1 << e);
`ifdef STREAM_WRR_ARBITER_PKT_EN
        chk("sb_last", int'(oup_last), int'(inp_last[e]));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) inp_data[i] = 8'(8'hA0 + i);
    set_w(1, 1, 1, 1);
    inp_valid = 4'b1111;
    oup_ready = 1'b1;

    // Reset held: outputs quiet even with all inputs valid.
    @(negedge clk);
    chk("rst_valid", int'(oup_valid), 0);
    chk("rst_ready", int'(inp_ready), 0);
    chk("rst_idx", int'(idx), 0);
    inp_valid = '0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", int'(oup_valid), 0);
    chk("idle_idx", int'(idx), 0);
    cyc();

    // Weights {3,1,0,2}, all valid, always ready.
    set_w(3, 1, 0, 2);
    begin
      int seq[12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
      for (int k = 0; k < 12; k++) push(seq[k]);
    end
    inp_valid = 4'b1111;
    repeat (12) cyc();
    inp_valid = '0;
    cyc();

    // Backpressure: input 1 frozen for 5 cycles, input 0 joins in cycle 2.
    set_w(1, 1, 1, 1);
    push(1); push(0);
    inp_valid = 4'b0010;
    oup_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) inp_valid = 4'b0011;
      @(negedge clk);
      chk("bp_idx", int'(idx), 1);
      chk("bp_data", int'(oup_data), 'hA1);
      chk("bp_valid", int'(oup_valid), 1);
      chk("bp_ready", int'(inp_ready), 0);
      cyc();
    end
    oup_ready = 1'b1;
    cyc();
    cyc();
    inp_valid = '0;
    cyc();

    // Forfeit: input 2 (weight 4) drops valid after 2 beats.
    set_w(1, 1, 4, 1);
    push(2); push(2); push(3);
    inp_valid = 4'b1100;
    cyc();
    cyc();
    inp_valid = 4'b1000;
    @(negedge clk);
    chk("forfeit_bubble", int'(oup_valid), 0);
    cyc();
    cyc();
    inp_valid = '0;
    cyc();

    // Reset during input 1's second beat of three.
    set_w(1, 3, 1, 1);
    push(1); push(0);
    inp_valid = 4'b0010;
    cyc();
    rst = 1'b1;
    inp_valid = 4'b0011;
    @(negedge clk);
    chk("midrst_valid", int'(oup_valid), 0);
    chk("midrst_ready", int'(inp_ready), 0);
    chk("midrst_idx", int'(idx), 0);
    cyc();
    rst = 1'b0;
    cyc();
    inp_valid = '0;
    cyc();

    // Input 0 weight 3 -> 1 during its turn: turn keeps 3 beats, next turn has 1.
    set_w(3, 1, 1, 1);
    begin
      int seq[7] = '{1, 0, 0, 0, 1, 0, 1};
      for (int k = 0; k < 7; k++) push(seq[k]);
    end
    inp_valid = 4'b0011;
    cyc();
    cyc();
    weight[0] = 4'd1;
    repeat (5) cyc();
    inp_valid = '0;
    cyc();

`ifdef STREAM_WRR_ARBITER_PKT_EN
    // Packet of 4 beats on input 0 (weight 1) with a valid gap; input 1 waits.
    set_w(1, 1, 1, 1);
    push(0); push(0); push(0); push(0); push(1);
    inp_last = 4'b0010;
    inp_valid = 4'b0011;
    cyc();
    inp_valid = 4'b0010;
    @(negedge clk);
    chk("pkt_gap_valid", int'(oup_valid), 0);
    chk("pkt_gap_idx", int'(idx), 0);
    cyc();
    inp_valid = 4'b0011;
    cyc();
    cyc();
    inp_last = 4'b0011;
    cyc();
    inp_valid = 4'b0010;
    cyc();
    inp_valid = '0;
    cyc();
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
